// File: rtl/cordic_byte_host_if.sv
// Signal bundle between the system requester, the byte host and the CORDIC wrapper link.
// Every channel (req, rsp, link_tx, link_rx) moves one item on an edge where valid and ready are both high; the producer keeps valid and data stable until then.
interface cordic_byte_host_if #(
   parameter int WIDTH   = 16,
   parameter int PHASE_W = 32
);
   logic               req_valid;
   logic               req_ready;
   logic [WIDTH-1:0]   req_x;
   logic [WIDTH-1:0]   req_y;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [WIDTH-1:0]   rsp_mag;
   logic [PHASE_W-1:0] rsp_phase;
   logic               rsp_err;
   logic [7:0]         link_tx_data;
   logic               link_tx_valid;
   logic               link_tx_ready;
   logic [7:0]         link_rx_data;
   logic               link_rx_valid;
   logic               link_rx_ready;

   // host side
   modport master (
      input  req_valid, req_x, req_y, rsp_ready, link_tx_ready, link_rx_data, link_rx_valid,
      output req_ready, rsp_valid, rsp_mag, rsp_phase, rsp_err, link_tx_data, link_tx_valid,
             link_rx_ready
   );

   // requester plus wrapper side
   modport slave (
      output req_valid, req_x, req_y, rsp_ready, link_tx_ready, link_rx_data, link_rx_valid,
      input  req_ready, rsp_valid, rsp_mag, rsp_phase, rsp_err, link_tx_data, link_tx_valid,
             link_rx_ready
   );
endinterface

// File: rtl/cordic_byte_host.sv
// Byte-serial CORDIC link initiator: sends X/Y as 4 bytes, gathers a 6-byte mag/phase reply.
// Optional response watchdog enabled by defining CORDIC_HOST_TIMEOUT_EN.
module cordic_byte_host #(
   parameter int WIDTH          = 16,
   parameter int PHASE_W        = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                rst,
   cordic_byte_host_if.master  bus,
   output logic                busy,
   output logic [1:0]          dbg_state
);

   localparam int SHADOW_W = WIDTH + PHASE_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TX   = 2'd1,
      S_RX   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          idx_q, idx_d;
   logic [WIDTH-1:0]    x_q, x_d;
   logic [WIDTH-1:0]    y_q, y_d;
   logic [SHADOW_W-1:0] shadow_q, shadow_d;
   logic [7:0]          tx_byte;

`ifdef CORDIC_HOST_TIMEOUT_EN
   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         shadow_q <= '0;
`ifdef CORDIC_HOST_TIMEOUT_EN
         wd_q     <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         x_q      <= x_d;
         y_q      <= y_d;
         shadow_q <= shadow_d;
`ifdef CORDIC_HOST_TIMEOUT_EN
         wd_q     <= wd_d;
         err_q    <= err_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      x_d      = x_q;
      y_d      = y_q;
      shadow_d = shadow_q;
`ifdef CORDIC_HOST_TIMEOUT_EN
      wd_d     = wd_q;
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               x_d      = bus.req_x;
               y_d      = bus.req_y;
               idx_d    = '0;
               shadow_d = '0;
               state_d  = S_TX;
            end
         end
         S_TX: begin
            if (bus.link_tx_ready) begin
               if (idx_q == 3'd3) begin
                  idx_d   = '0;
                  state_d = S_RX;
`ifdef CORDIC_HOST_TIMEOUT_EN
                  wd_d    = '0;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         S_RX: begin
            if (bus.link_rx_valid) begin
               // idx selects the byte lane: mag low/high, then phase bytes LSB first
               shadow_d[{idx_q, 3'b000} +: 8] = bus.link_rx_data;
`ifdef CORDIC_HOST_TIMEOUT_EN
               wd_d = '0;
`endif
               if (idx_q == 3'd5) begin
                  idx_d   = '0;
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
`ifdef CORDIC_HOST_TIMEOUT_EN
            else if (wd_q == WD_LAST) begin
               // this idle cycle is the last one allowed; abort with an empty result
               shadow_d = '0;
               err_d    = 1'b1;
               idx_d    = '0;
               state_d  = S_DONE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end
         S_DONE: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
`ifdef CORDIC_HOST_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_byte = '0;
      if (state_q == S_TX) begin
         case (idx_q[1:0])
            2'd0:    tx_byte = x_q[7:0];
            2'd1:    tx_byte = x_q[15:8];
            2'd2:    tx_byte = y_q[7:0];
            default: tx_byte = y_q[15:8];
         endcase
      end
   end

   // Handshake outputs depend on state only, so no input reaches them combinationally.
   assign bus.req_ready     = (state_q == S_IDLE);
   assign busy              = (state_q != S_IDLE);
   assign bus.link_tx_valid = (state_q == S_TX);
   assign bus.link_tx_data  = tx_byte;
   assign bus.link_rx_ready = (state_q == S_RX);
   assign bus.rsp_valid     = (state_q == S_DONE);
   assign bus.rsp_mag       = (state_q == S_DONE) ? shadow_q[WIDTH-1:0] : '0;
   assign bus.rsp_phase     = (state_q == S_DONE) ? shadow_q[SHADOW_W-1:WIDTH] : '0;
`ifdef CORDIC_HOST_TIMEOUT_EN
   assign bus.rsp_err       = err_q;
`else
   assign bus.rsp_err       = 1'b0;
`endif
   assign dbg_state         = state_q;

endmodule

// File: tb/tb_cordic_byte_host.sv
// Directed self-checking bench for cordic_byte_host: transactions, backpressure, gaps, reset, timeout.
module tb_cordic_byte_host;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy;
   logic [1:0] dbg_state;
   int         n_cmp  = 0;
   int         n_fail = 0;

   cordic_byte_host_if bus ();

   cordic_byte_host #(
      .WIDTH(16),
      .PHASE_W(32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .busy(busy),
      .dbg_state(dbg_state)
   );

   // clock/reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   // driver tasks (inputs change at negedge, outputs sampled at negedge)
   task automatic start_request(input logic [15:0] x, input logic [15:0] y);
      bus.req_x     = x;
      bus.req_y     = y;
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_x     = $urandom_range(0, 65535);
      bus.req_y     = $urandom_range(0, 65535);
   endtask

   task automatic drive_rx_byte(input logic [7:0] b);
      bus.link_rx_valid = 1'b1;
      bus.link_rx_data  = b;
      @(negedge clk);
      bus.link_rx_valid = 1'b0;
      bus.link_rx_data  = 8'h00;
   endtask

   task automatic consume_response();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.link_tx_valid !== 1'b0 ||
          bus.link_rx_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 ||
          bus.rsp_mag !== 16'h0 || bus.rsp_phase !== 32'h0 || bus.link_tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%0b busy=%0b txv=%0b rxr=%0b rspv=%0b err=%0b mag=%h ph=%h txd=%h want rdy=1 rest 0",
                  bus.req_ready, busy, bus.link_tx_valid, bus.link_rx_ready, bus.rsp_valid,
                  bus.rsp_err, bus.rsp_mag, bus.rsp_phase, bus.link_tx_data);
      end
      // link inputs must be ignored while idle
      bus.link_rx_valid = 1'b1;
      bus.link_rx_data  = 8'hAA;
      @(negedge clk);
      bus.link_rx_valid = 1'b0;
      n_cmp++;
      if (dbg_state !== 2'd0 || bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_ignores_rx: got state=%0d rdy=%0b want state=0 rdy=1", dbg_state, bus.req_ready);
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp_q[$];
      exp_q = '{8'hE0, 8'h2E, 8'h40, 8'h1F};
      bus.link_tx_ready = 1'b1;
      start_request(16'h2EE0, 16'h1F40);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (bus.link_tx_valid !== 1'b1 || bus.link_tx_data !== exp_q[i]) begin
            n_fail++;
            $display("FAIL basic_tx_byte%0d: got valid=%0b data=%h want valid=1 data=%h",
                     i, bus.link_tx_valid, bus.link_tx_data, exp_q[i]);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (bus.link_rx_ready !== 1'b1 || bus.link_tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_rx_ready: got rxr=%0b txv=%0b want rxr=1 txv=0", bus.link_rx_ready, bus.link_tx_valid);
      end
      exp_q = '{8'h54, 8'h38, 8'h78, 8'h56, 8'h34, 8'h12};
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_rsp%0d: got rsp_valid=%0b want 0", i, bus.rsp_valid);
         end
         drive_rx_byte(exp_q[i]);
      end
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_mag !== 16'h3854 || bus.rsp_phase !== 32'h12345678 ||
          bus.rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_rsp: got v=%0b mag=%h ph=%h err=%0b want v=1 mag=3854 ph=12345678 err=0",
                  bus.rsp_valid, bus.rsp_mag, bus.rsp_phase, bus.rsp_err);
      end
      consume_response();
      n_cmp++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_return_idle: got rdy=%0b rspv=%0b busy=%0b want 1 0 0", bus.req_ready, bus.rsp_valid, busy);
      end
   endtask

   task automatic test_tx_backpressure();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      int sent = 0;
      int stall = 0;
      exp_q = '{8'h68, 8'hC5, 8'h10, 8'h27};
      bus.link_tx_ready = 1'b1;
      start_request(16'hC568, 16'h2710);
      for (int c = 0; c < 20 && sent < 4; c++) begin
         if (sent == 1 && stall < 3) begin
            bus.link_tx_ready = 1'b0;
            stall++;
            n_cmp++;
            if (bus.link_tx_valid !== 1'b1 || bus.link_tx_data !== 8'hC5) begin
               n_fail++;
               $display("FAIL bp_hold%0d: got valid=%0b data=%h want valid=1 data=c5", stall, bus.link_tx_valid, bus.link_tx_data);
            end
         end else begin
            bus.link_tx_ready = 1'b1;
         end
         if (bus.link_tx_ready && bus.link_tx_valid) begin
            b = exp_q.pop_front();
            sent++;
            n_cmp++;
            if (bus.link_tx_data !== b) begin
               n_fail++;
               $display("FAIL bp_tx_byte%0d: got %h want %h", sent - 1, bus.link_tx_data, b);
            end
         end
         @(negedge clk);
      end
      bus.link_tx_ready = 1'b1;
      n_cmp++;
      if (sent != 4 || bus.link_tx_valid !== 1'b0 || bus.link_rx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_done: got sent=%0d txv=%0b rxr=%0b want sent=4 txv=0 rxr=1", sent, bus.link_tx_valid, bus.link_rx_ready);
      end
      drive_rx_byte(8'h01); drive_rx_byte(8'h80); drive_rx_byte(8'hFF);
      drive_rx_byte(8'hFF); drive_rx_byte(8'hFF); drive_rx_byte(8'hFF);
      n_cmp++;
      if (bus.rsp_mag !== 16'h8001 || bus.rsp_phase !== 32'hFFFFFFFF) begin
         n_fail++;
         $display("FAIL bp_rsp: got mag=%h ph=%h want mag=8001 ph=ffffffff", bus.rsp_mag, bus.rsp_phase);
      end
      consume_response();
   endtask

   task automatic test_rx_gaps_hold();
      logic [7:0] rx_q[$];
      bus.link_tx_ready = 1'b1;
      start_request(16'h0102, 16'h0304);
      repeat (4) @(negedge clk);
      rx_q = '{8'hEF, 8'hBE, 8'h0D, 8'hF0, 8'hAD, 8'hDE};
      for (int i = 0; i < 6; i++) begin
         drive_rx_byte(rx_q[i]);
         if (i < 5) begin
            bus.link_rx_data = 8'h99;
            repeat (5) @(negedge clk);
         end
      end
      bus.link_rx_data = 8'h00;
      for (int c = 0; c < 10; c++) begin
         n_cmp++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_mag !== 16'hBEEF || bus.rsp_phase !== 32'hDEADF00D ||
             bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_hold_c%0d: got v=%0b mag=%h ph=%h rdy=%0b want v=1 mag=beef ph=deadf00d rdy=0",
                     c, bus.rsp_valid, bus.rsp_mag, bus.rsp_phase, bus.req_ready);
         end
         @(negedge clk);
      end
      consume_response();
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL gaps_release: got rdy=%0b want 1", bus.req_ready);
      end
   endtask

   task automatic test_reset_mid_rx();
      logic [7:0] exp_q[$];
      bus.link_tx_ready = 1'b1;
      start_request(16'h1111, 16'h2222);
      repeat (4) @(negedge clk);
      drive_rx_byte(8'hA1); drive_rx_byte(8'hA2); drive_rx_byte(8'hA3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.link_rx_ready !== 1'b0 ||
          bus.link_tx_valid !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_mag !== 16'h0 ||
          bus.rsp_phase !== 32'h0 || bus.rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL midrx_reset: got rdy=%0b busy=%0b rxr=%0b txv=%0b rspv=%0b mag=%h ph=%h err=%0b want rdy=1 rest 0",
                  bus.req_ready, busy, bus.link_rx_ready, bus.link_tx_valid, bus.rsp_valid,
                  bus.rsp_mag, bus.rsp_phase, bus.rsp_err);
      end
      exp_q = '{8'hA8, 8'h61, 8'h20, 8'hD1};
      start_request(16'h61A8, 16'hD120);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (bus.link_tx_valid !== 1'b1 || bus.link_tx_data !== exp_q[i]) begin
            n_fail++;
            $display("FAIL midrx_tx_byte%0d: got valid=%0b data=%h want valid=1 data=%h",
                     i, bus.link_tx_valid, bus.link_tx_data, exp_q[i]);
         end
         @(negedge clk);
      end
      drive_rx_byte(8'h11); drive_rx_byte(8'h22); drive_rx_byte(8'h33);
      drive_rx_byte(8'h44); drive_rx_byte(8'h55); drive_rx_byte(8'h66);
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_mag !== 16'h2211 || bus.rsp_phase !== 32'h66554433) begin
         n_fail++;
         $display("FAIL midrx_new_rsp: got v=%0b mag=%h ph=%h want v=1 mag=2211 ph=66554433",
                  bus.rsp_valid, bus.rsp_mag, bus.rsp_phase);
      end
      consume_response();
   endtask

   task automatic test_timeout();
      bus.link_tx_ready = 1'b1;
      start_request(16'h7FFF, 16'h8000);
      repeat (4) @(negedge clk);
`ifdef CORDIC_HOST_TIMEOUT_EN
      begin
         int wait_c = -1;
         for (int c = 0; c < 40; c++) begin
            if (bus.rsp_valid === 1'b1) begin
               wait_c = c;
               break;
            end
            @(negedge clk);
         end
         n_cmp++;
         if (wait_c != 16) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d RX cycles want 16", wait_c);
         end
         n_cmp++;
         if (bus.rsp_err !== 1'b1 || bus.rsp_mag !== 16'h0 || bus.rsp_phase !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout_rsp: got err=%0b mag=%h ph=%h want err=1 mag=0 ph=0",
                     bus.rsp_err, bus.rsp_mag, bus.rsp_phase);
         end
         consume_response();
         n_cmp++;
         if (bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_clear: got err=%0b rdy=%0b want err=0 rdy=1", bus.rsp_err, bus.req_ready);
         end
      end
`else
      repeat (100) @(negedge clk);
      n_cmp++;
      if (dbg_state !== 2'd2 || bus.link_rx_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
          bus.rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL no_timeout_wait: got state=%0d rxr=%0b rspv=%0b err=%0b want state=2 rxr=1 rspv=0 err=0",
                  dbg_state, bus.link_rx_ready, bus.rsp_valid, bus.rsp_err);
      end
      drive_rx_byte(8'h0F); drive_rx_byte(8'hF0); drive_rx_byte(8'h00);
      drive_rx_byte(8'h00); drive_rx_byte(8'h00); drive_rx_byte(8'h80);
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_mag !== 16'hF00F || bus.rsp_phase !== 32'h80000000 ||
          bus.rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL no_timeout_rsp: got v=%0b mag=%h ph=%h err=%0b want v=1 mag=f00f ph=80000000 err=0",
                  bus.rsp_valid, bus.rsp_mag, bus.rsp_phase, bus.rsp_err);
      end
      consume_response();
`endif
   endtask

   initial begin
      rst               = 1'b1;
      bus.req_valid     = 1'b0;
      bus.req_x         = '0;
      bus.req_y         = '0;
      bus.rsp_ready     = 1'b0;
      bus.link_tx_ready = 1'b0;
      bus.link_rx_data  = '0;
      bus.link_rx_valid = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_tx_backpressure();
      test_rx_gaps_hold();
      test_reset_mid_rx();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cordic_byte_host.md
# cordic_byte_host

Host-side initiator for the byte-serial CORDIC link. Accepts a parallel (X, Y) request, serialises it LSB-first as 4 bytes onto the link, collects the 6-byte response, and presents it as parallel magnitude and phase. Sits between a system-side requester and the CORDIC wrapper's 8-bit data / valid / ready pins, driving the side opposite the wrapper.

## Interface

Parameters:
- WIDTH, 16: operand and magnitude width. Fixed at 16 for the 2-byte link format.
- PHASE_W, 32: phase width (4 bytes).
- TIMEOUT_CYCLES, 1024: response watchdog limit. Used only with the configuration macro.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  host idle, can accept a request
- req_x  in  16  signed X operand
- req_y  in  16  signed Y operand
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_mag  out  16  magnitude
- rsp_phase  out  32  signed phase
- rsp_err  out  1  response aborted by timeout
- busy  out  1  high in any state other than IDLE
- link_tx_data  out  8  byte to the wrapper (wrapper ui_in)
- link_tx_valid  out  1  byte valid (wrapper in_valid)
- link_tx_ready  in  1  wrapper in_ready
- link_rx_data  in  8  byte from the wrapper (wrapper uo_out)
- link_rx_valid  in  1  wrapper out_valid
- link_rx_ready  out  1  wrapper out_ready

## Operation

- FSM states: IDLE, TX, RX, DONE. A 3-bit byte index `idx` runs within TX and RX.
- **IDLE**
  - req_ready=1.
  - When req_valid&req_ready is high at an edge, the host latches req_x and req_y, clears idx, and moves to TX.
- **TX**
  - link_tx_valid=1.
  - link_tx_data byte order by idx: 0: X[7:0], 1: X[15:8], 2: Y[7:0], 3: Y[15:8].
  - A byte transfers on an edge where link_tx_valid&link_tx_ready is high. idx then increments.
  - Data and valid stay stable until the byte transfers.
  - After byte 3 transfers, the host clears idx and moves to RX.
- **RX**
  - link_rx_ready=1.
  - On each edge where link_rx_valid is high, the host captures link_rx_data into the result shadow register at byte position idx, then increments idx.
  - Byte order: 0–1 mag[7:0], mag[15:8]; 2–5 phase[7:0] … phase[31:24].
  - After byte 5 is captured, the host moves to DONE.
- **DONE**
  - rsp_valid=1; rsp_mag and rsp_phase are driven from the shadow register.
  - When rsp_valid&rsp_ready is high, the host returns to IDLE.
- **Ignored inputs**
  - link_rx_valid is ignored outside RX.
  - link_tx_ready is ignored outside TX.
  - req_x and req_y are ignored except at acceptance.
- **Arithmetic:** none. Bytes are concatenated as raw two's-complement, with no sign extension or rounding.
- **Reset:** all outputs go to 0 and the FSM goes to IDLE. From the first cycle after reset, req_ready=1.
  - Reset during TX, RX or DONE discards the transaction and the partial response.
  - The link is not resynchronised. The system must also reset the wrapper.

## Timing

- req_ready and busy are combinational from the state. link_tx_valid, link_rx_ready and rsp_valid are also combinational from the state and carry no combinational path from any input.
- Request accepted at edge E0:
  - link_tx_valid is high in the cycle after E0.
  - With link_tx_ready held high, the 4 bytes transfer on edges E1..E4.
  - link_rx_ready is high from the cycle after E4.
- Last rx byte captured at edge Er: rsp_valid is high in the cycle after Er.
- rsp_valid&rsp_ready at edge Ed: req_ready is high in the cycle after Ed. Back-to-back requests therefore have one idle cycle between them.
- Minimum total, from request accept to rsp_valid: 11 cycles (4 TX + 6 RX + 1).
- Throughput: one byte per cycle per direction, maximum.

## Configuration

- Macro: CORDIC_HOST_TIMEOUT_EN.
- **Defined:**
  - A watchdog counter clears on entry to RX and on every captured rx byte, and increments in every other RX cycle.
  - When the counter reaches TIMEOUT_CYCLES, the host enters DONE with rsp_err=1 and rsp_mag=0, rsp_phase=0.
  - rsp_err clears on leaving DONE.
- **Undefined:**
  - No counter. rsp_err is tied to 0. RX waits indefinitely.

## Test plan

- **Basic transaction:** X=12000 (0x2EE0), Y=8000 (0x1F40), link_tx_ready held high.
  - TX bytes E0, 2E, 40, 1F on consecutive edges.
  - Feed response 54, 38, 78, 56, 34, 12 → rsp_mag=0x3854, rsp_phase=0x12345678, rsp_err=0.
- **TX backpressure:** X=-15000 (0xC568), Y=10000 (0x2710); link_tx_ready low for 3 cycles while byte 1 is offered.
  - link_tx_data holds C5 with valid high.
  - Full sequence 68, C5, 10, 27, with no byte dropped or duplicated.
- **RX gaps and response hold:** link_rx_valid pulsed with 5-cycle gaps between bytes; rsp_ready held low for 10 cycles.
  - Result is assembled correctly.
  - rsp_valid and the outputs stay stable; req_ready stays 0 until the handshake.
- **Reset mid-RX:** assert rst after rx byte 2.
  - Next cycle: all outputs 0, req_ready=1.
  - A new request X=25000, Y=-12000 sends A8, 61, 20, D1.
- **Timeout (macro defined, TIMEOUT_CYCLES=16):** no rx bytes after TX.
  - rsp_valid=1 with rsp_err=1, mag=0 and phase=0 after 16 RX cycles.
- **Timeout (macro undefined):** same stimulus.
  - The host is still in RX after 100 cycles, with rsp_err=0.
